fp_mul_scheduler: RTL and testbench

//  Shares one combinational single-precision FP multiplier (module `multiplier`) among
//  NUM_REQ requesters. Round-robin arbitration picks one operand pair per cycle. The pair

---
 rtl/fp_mul_pkg.sv | 15 +
 rtl/fp_rr_arbiter.sv | 30 +++
 rtl/multiplier.sv | 71 +++++++
 rtl/fp_mul_scheduler.sv | 115 +++++++++++
 tb/tb_fp_mul_scheduler.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the FP multiply scheduler.
package fp_mul_pkg;

  localparam int unsigned FP_W    = 32;
  localparam int unsigned MAX_REQ = 8;

  typedef logic [FP_W-1:0] fp32_t;

  // Extract requester idx's operand from a packed operand bus (zero-extended to MAX_REQ lanes).
  function automatic fp32_t operand_at(input logic [MAX_REQ*FP_W-1:0] bus,
                                       input int unsigned            idx);
    return bus[FP_W*idx +: FP_W];
  endfunction

endpackage

// File: rtl/fp_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr (modulo NUM_REQ) wins.
module fp_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    win,
  output logic               any
);

  int unsigned idx;

  always_comb begin
    grant = '0;
    win   = '0;
    any   = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        win        = ID_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multiplier.sv
// Combinational IEEE-754 single-precision multiplier, round-to-nearest-even.
// Denormal inputs and results are flushed to signed zero.
module multiplier (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] Output
);

  logic               sign;
  logic [7:0]         ea, eb;
  logic [22:0]        fa, fb;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [47:0]        prod;
  logic signed [9:0]  exp_sum;
  logic [22:0]        mant;
  logic               guard, sticky;
  logic [23:0]        rnd;

  always_comb begin
    sign    = a[31] ^ b[31];
    ea      = a[30:23];
    eb      = b[30:23];
    fa      = a[22:0];
    fb      = b[22:0];
    a_nan   = (ea == 8'hFF) && (fa != '0);
    b_nan   = (eb == 8'hFF) && (fb != '0);
    a_inf   = (ea == 8'hFF) && (fa == '0);
    b_inf   = (eb == 8'hFF) && (fb == '0);
    a_zero  = (ea == 8'h00);
    b_zero  = (eb == 8'h00);
    prod    = 48'({1'b1, fa}) * 48'({1'b1, fb});
    exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    mant    = '0;
    guard   = 1'b0;
    sticky  = 1'b0;
    Output  = '0;

    // Product of two 1.x mantissas lies in [1,4); renormalise when it reaches 2.
    if (prod[47]) begin
      mant    = prod[46:24];
      guard   = prod[23];
      sticky  = |prod[22:0];
      exp_sum = exp_sum + 10'sd1;
    end else begin
      mant    = prod[45:23];
      guard   = prod[22];
      sticky  = |prod[21:0];
    end

    rnd = {1'b0, mant} + 24'(guard & (sticky | mant[0]));
    if (rnd[23]) begin
      exp_sum = exp_sum + 10'sd1;
    end
    mant = rnd[22:0];

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      Output = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      Output = {sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      Output = {sign, 31'd0};
    end else if (exp_sum >= 10'sd255) begin
      Output = {sign, 8'hFF, 23'd0};
    end else if (exp_sum <= 10'sd0) begin
      Output = {sign, 31'd0};
    end else begin
      Output = {sign, exp_sum[7:0], mant};
    end
  end

endmodule

// File: rtl/fp_mul_scheduler.sv
// Shares one combinational FP32 multiplier among NUM_REQ requesters through a
// round-robin arbiter and a two-stage stallable pipeline with a tagged response.
module fp_mul_scheduler
  import fp_mul_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [FP_W-1:0]         resp_data,
  output logic [ID_W-1:0]         resp_id,
  output logic                    busy,
  output logic [CNT_W-1:0]        done_cnt
);

  logic [NUM_REQ-1:0]      grant;
  logic [ID_W-1:0]         win;
  logic                    any;
  logic [ID_W-1:0]         rr_ptr;
  logic [ID_W-1:0]         ptr_next;
  logic                    adv1, adv2, hs;
  logic                    s1_valid, s2_valid;
  fp32_t                   s1_a, s1_b;
  logic [ID_W-1:0]         s1_id;
  fp32_t                   mul_out;
  fp32_t                   win_a, win_b;
  logic [MAX_REQ*FP_W-1:0] a_ext, b_ext;

  fp_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .win   (win),
    .any   (any)
  );

  multiplier u_mul (
    .a      (s1_a),
    .b      (s1_b),
    .Output (mul_out)
  );

  always_comb begin
    adv2 = !s2_valid || resp_ready;
    adv1 = !s1_valid || adv2;
    // Reset gating keeps req_ready low while rst_n is held, even though adv1 is 1.
    req_ready = (any && adv1 && rst_n) ? grant : '0;
    hs        = |(req_valid & req_ready);
    ptr_next  = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    a_ext = '0;
    b_ext = '0;
    a_ext[NUM_REQ*FP_W-1:0] = req_a;
    b_ext[NUM_REQ*FP_W-1:0] = req_b;
    win_a = operand_at(a_ext, 32'(win));
    win_b = operand_at(b_ext, 32'(win));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (hs) begin
      rr_ptr <= ptr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
    end else if (adv1) begin
      s1_valid <= hs;
      s1_a     <= win_a;
      s1_b     <= win_b;
      s1_id    <= win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      resp_data <= '0;
      resp_id   <= '0;
    end else if (adv2) begin
      s2_valid  <= s1_valid;
      resp_data <= mul_out;
      resp_id   <= s1_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= '0;
    end else if (s2_valid && resp_ready) begin
      done_cnt <= done_cnt + 1'b1;
    end
  end

  assign resp_valid = s2_valid;
  assign busy       = s1_valid || s2_valid;

endmodule

// File: tb/tb_fp_mul_scheduler.sv
// Directed bench for fp_mul_scheduler; a second CNT_W=4 instance shares the stimulus.
module tb_fp_mul_scheduler;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready, req_ready4;
  logic [NUM_REQ*32-1:0] req_a, req_b;
  logic                 resp_valid, resp_valid4;
  logic                 resp_ready;
  logic [31:0]          resp_data, resp_data4;
  logic [ID_W-1:0]      resp_id, resp_id4;
  logic                 busy, busy4;
  logic [31:0]          done_cnt;
  logic [3:0]           done_cnt4;

  logic [31:0] a_tab   [NUM_REQ] = '{32'h3FC0_0000, 32'h4040_0000, 32'hC000_0000, 32'h3F80_0000};
  logic [31:0] b_tab   [NUM_REQ] = '{32'h4000_0000, 32'h4000_0000, 32'h3F00_0000, 32'h3FC0_0000};
  // 1.5*2=3, 3*2=6, -2*0.5=-1, 1*1.5=1.5
  logic [31:0] exp_tab [NUM_REQ] = '{32'h4040_0000, 32'h40C0_0000, 32'hBF80_0000, 32'h3FC0_0000};

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[32*i +: 32] = a_tab[i];
      req_b[32*i +: 32] = b_tab[i];
    end
  end

  fp_mul_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(32)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy),
    .done_cnt   (done_cnt)
  );

  fp_mul_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(4)) u_dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready4),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid4),
    .resp_ready (resp_ready),
    .resp_data  (resp_data4),
    .resp_id    (resp_id4),
    .busy       (busy4),
    .done_cnt   (done_cnt4)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #4 rst_n = 1'b1;
  endtask

  int          n_got;
  logic [1:0]  got_id   [8];
  logic [31:0] got_data [8];
  logic [3:0]  pending;
  int          exp_order [4] = '{1, 2, 3, 0};

  initial begin
    rst_n      = 1'b0;
    req_valid  = '1;
    resp_ready = 1'b0;
    #4;
    check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done_cnt", 64'(done_cnt), 64'd0);
    check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    check_eq("rst_resp_data", 64'(resp_data), 64'd0);
    req_valid = '0;
    #8 rst_n = 1'b1;

    // Single op from requester 0.
    @(posedge clk); #1;
    req_valid  = 4'b0001;
    resp_ready = 1'b1;
    #3 check_eq("t1_req_ready", 64'(req_ready), 64'h1);
    @(posedge clk); #1;
    req_valid = '0;
    #3;
    check_eq("t1_busy_s1", 64'(busy), 64'd1);
    check_eq("t1_no_resp_yet", 64'(resp_valid), 64'd0);
    @(posedge clk); #4;
    check_eq("t1_resp_valid", 64'(resp_valid), 64'd1);
    check_eq("t1_resp_data", 64'(resp_data), 64'h4040_0000);
    check_eq("t1_resp_id", 64'(resp_id), 64'd0);
    @(posedge clk); #4;
    check_eq("t1_done_cnt", 64'(done_cnt), 64'd1);
    check_eq("t1_resp_gone", 64'(resp_valid), 64'd0);

    // Sign: requester 2.
    @(posedge clk); #1;
    req_valid = 4'b0100;
    #3 check_eq("t2_req_ready", 64'(req_ready), 64'h4);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #4;
    check_eq("t2_resp_valid", 64'(resp_valid), 64'd1);
    check_eq("t2_resp_data", 64'(resp_data), 64'hBF80_0000);
    check_eq("t2_resp_id", 64'(resp_id), 64'd2);
    @(posedge clk); #4;
    check_eq("t2_done_cnt", 64'(done_cnt), 64'd2);

    // Contention with all requesters valid.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      req_valid = (c < 5) ? 4'b1111 : 4'b0000;
      #3;
      if (c < 5) check_eq($sformatf("t3_grant_c%0d", c), 64'(req_ready), 64'(4'b1 << (c % 4)));
      if (c >= 2) begin
        check_eq($sformatf("t3_valid_c%0d", c), 64'(resp_valid), 64'd1);
        check_eq($sformatf("t3_id_c%0d", c), 64'(resp_id), 64'((c - 2) % 4));
        check_eq($sformatf("t3_data_c%0d", c), 64'(resp_data), 64'(exp_tab[(c - 2) % 4]));
      end
    end
    @(posedge clk); #4;
    check_eq("t3_done_cnt", 64'(done_cnt), 64'd5);

    // Backpressure: pointer now at 1, resp_ready low for 5 cycles.
    pending = 4'b1111;
    n_got   = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      req_valid  = pending;
      resp_ready = (c >= 5);
      #3;
      if (c == 0) check_eq("t4_accept0", 64'(req_ready), 64'h2);
      if (c == 1) check_eq("t4_accept1", 64'(req_ready), 64'h4);
      if (c >= 2 && c <= 4) begin
        check_eq($sformatf("t4_stall_ready_c%0d", c), 64'(req_ready), 64'd0);
        check_eq($sformatf("t4_stall_valid_c%0d", c), 64'(resp_valid), 64'd1);
        check_eq($sformatf("t4_stall_id_c%0d", c), 64'(resp_id), 64'd1);
        check_eq($sformatf("t4_stall_data_c%0d", c), 64'(resp_data), 64'h40C0_0000);
      end
      if (resp_valid && resp_ready && n_got < 8) begin
        got_id[n_got]   = resp_id;
        got_data[n_got] = resp_data;
        n_got++;
      end
      pending = pending & ~req_ready;
    end
    check_eq("t4_count", 64'(n_got), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < n_got) begin
        check_eq($sformatf("t4_id%0d", i), 64'(got_id[i]), 64'(exp_order[i]));
        check_eq($sformatf("t4_data%0d", i), 64'(got_data[i]), 64'(exp_tab[exp_order[i]]));
      end
    end
    check_eq("t4_done_cnt", 64'(done_cnt), 64'd9);

    // Reset mid-op with both stages full.
    req_valid  = '0;
    resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      req_valid = (c < 2) ? 4'b1111 : 4'b0000;
    end
    #3;
    check_eq("t5_full_busy", 64'(busy), 64'd1);
    check_eq("t5_full_valid", 64'(resp_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("t5_rst_valid", 64'(resp_valid), 64'd0);
    check_eq("t5_rst_busy", 64'(busy), 64'd0);
    check_eq("t5_rst_done", 64'(done_cnt), 64'd0);
    check_eq("t5_rst_ready", 64'(req_ready), 64'd0);
    #2 rst_n = 1'b1;
    resp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #4;
      check_eq($sformatf("t5_no_stale_c%0d", c), 64'(resp_valid), 64'd0);
    end

    // 17 completions: 4-bit counter wraps to 1; first grant proves rr_ptr reset to 0.
    for (int c = 0; c < 22; c++) begin
      @(posedge clk); #1;
      req_valid = (c < 17) ? 4'b1111 : 4'b0000;
      #3;
      if (c == 0) check_eq("t5_ptr_reset", 64'(req_ready), 64'h1);
    end
    check_eq("t6_done_cnt32", 64'(done_cnt), 64'd17);
    check_eq("t6_done_cnt4", 64'(done_cnt4), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
